// File: rtl/ram_test_master.sv
// Avalon-MM RAM test master: writes seed+idx across a word window, reads it back
// in a pipelined pass and reports the mismatch count and first failing address.
module ram_test_master #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [13:0]       length,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              cfg_err,
  output logic [13:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam int SUM_W = ((ADDR_W > 14) ? ADDR_W : 14) + 1;

  state_t            state_q, state_d;
  logic [13:0]       idx_q, idx_d;
  logic [13:0]       len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0] exp_data_q, exp_data_d;
  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              cfg_err_q, cfg_err_d;
  logic [13:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic              avm_chipselect_q, avm_chipselect_d;
  logic              avm_write_q, avm_write_d;
  logic              avm_read_q, avm_read_d;
  logic [3:0]        avm_byteenable_q, avm_byteenable_d;
  logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;

  logic [SUM_W-1:0]  end_sum;
  logic              cfg_bad;
  logic              is_last;
  logic              mismatch;

  assign end_sum  = SUM_W'(base_addr) + SUM_W'(length);
  assign cfg_bad  = (length == 14'd0) || (end_sum > SUM_W'(DEPTH));
  assign is_last  = (idx_q == (len_q - 14'd1));
  assign mismatch = rd_pending_q && (avm_readdata != exp_data_q);

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    len_d            = len_q;
    base_d           = base_q;
    seed_d           = seed_q;
    rd_pending_d     = 1'b0;
    exp_data_d       = exp_data_q;
    exp_addr_d       = exp_addr_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    cfg_err_d        = cfg_err_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;

    // The compare of the previous cycle's read runs alongside READ and DRAIN.
    if (mismatch) begin
      err_count_d = err_count_q + 14'd1;
      if (err_count_q == 14'd0) begin
        first_err_addr_d = exp_addr_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d           = base_addr;
          len_d            = length;
          seed_d           = seed;
          idx_d            = 14'd0;
          err_count_d      = 14'd0;
          first_err_addr_d = '0;
          pass_d           = 1'b0;
          if (cfg_bad) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cfg_err_d = 1'b1;
          end else begin
            state_d   = WRITE;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
          end
        end
      end
      WRITE: begin
        if (!avm_waitrequest) begin
          if (is_last) begin
            state_d = READ;
            idx_d   = 14'd0;
          end else begin
            idx_d = idx_q + 14'd1;
          end
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          rd_pending_d = 1'b1;
          exp_data_d   = seed_q + DATA_W'(idx_q);
          exp_addr_d   = base_q + ADDR_W'(idx_q);
          if (is_last) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 14'd1;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_d == 14'd0) && !cfg_err_q;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from next-state values, so a stall holds them.
    avm_chipselect_d = (state_d == WRITE) || (state_d == READ);
    avm_write_d      = (state_d == WRITE);
    avm_read_d       = (state_d == READ);
    avm_byteenable_d = avm_chipselect_d ? 4'hF : 4'h0;
    avm_address_d    = avm_chipselect_d ? (base_d + ADDR_W'(idx_d)) : '0;
    avm_writedata_d  = avm_write_d ? (seed_d + DATA_W'(idx_d)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      len_q            <= '0;
      base_q           <= '0;
      seed_q           <= '0;
      rd_pending_q     <= 1'b0;
      exp_data_q       <= '0;
      exp_addr_q       <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      cfg_err_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      avm_address_q    <= '0;
      avm_chipselect_q <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_read_q       <= 1'b0;
      avm_byteenable_q <= 4'h0;
      avm_writedata_q  <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      len_q            <= len_d;
      base_q           <= base_d;
      seed_q           <= seed_d;
      rd_pending_q     <= rd_pending_d;
      exp_data_q       <= exp_data_d;
      exp_addr_q       <= exp_addr_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      cfg_err_q        <= cfg_err_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      avm_address_q    <= avm_address_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_write_q      <= avm_write_d;
      avm_read_q       <= avm_read_d;
      avm_byteenable_q <= avm_byteenable_d;
      avm_writedata_q  <= avm_writedata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign cfg_err        = cfg_err_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_write      = avm_write_q;
  assign avm_read       = avm_read_q;
  assign avm_byteenable = avm_byteenable_q;
  assign avm_writedata  = avm_writedata_q;

endmodule

// File: tb/tb_ram_test_master.sv
// Directed bench for ram_test_master: RAM model with read corruption and
// scripted waitrequest stalls, plus a bus monitor logging accepted cycles.
module tb_ram_test_master;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5120;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [13:0]       length;
  logic [DATA_W-1:0] seed;
  logic              busy, done, pass, cfg_err;
  logic [13:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect, avm_write, avm_read;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              avm_waitrequest;

  int tests_run = 0;
  int tests_failed = 0;

  ram_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .cfg_err(cfg_err), .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];
  int   corrupt_a = -1;
  int   corrupt_b = -1;
  logic stall_en = 1'b0;
  logic new_run = 1'b0;
  int   wr_acc = 0, rd_acc = 0, wr_stall = 3, rd_stall = 3;

  // Stall the second accepted write and the third accepted read for 3 cycles each.
  assign avm_waitrequest = stall_en &&
    ((avm_write && wr_acc == 1 && wr_stall > 0) || (avm_read && rd_acc == 2 && rd_stall > 0));

  always @(posedge clk) begin
    if (new_run) begin
      wr_acc <= 0; rd_acc <= 0; wr_stall <= 3; rd_stall <= 3;
    end else begin
      if (avm_chipselect && avm_write) begin
        if (avm_waitrequest) wr_stall <= wr_stall - 1;
        else wr_acc <= wr_acc + 1;
      end
      if (avm_chipselect && avm_read) begin
        if (avm_waitrequest) rd_stall <= rd_stall - 1;
        else rd_acc <= rd_acc + 1;
      end
    end
    if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    if (avm_chipselect && avm_read && !avm_waitrequest)
      avm_readdata <= mem[avm_address] ^
        (((int'(avm_address) == corrupt_a) || (int'(avm_address) == corrupt_b)) ? 32'h1 : 32'h0);
  end

  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  int   cs_cycles = 0, overlap_cycles = 0, stall_cycles = 0, stall_violations = 0;
  logic prev_wait = 1'b0, prev_write = 1'b0, prev_read = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0]       prev_data = '0;

  // Bus monitor sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (new_run) begin
      wr_addr_log.delete(); wr_data_log.delete(); rd_addr_log.delete();
      cs_cycles = 0; overlap_cycles = 0; stall_cycles = 0; stall_violations = 0;
      prev_wait = 1'b0;
    end
    if (avm_chipselect) cs_cycles++;
    if (avm_write && avm_read) overlap_cycles++;
    if (prev_wait && (avm_address != prev_addr || avm_write != prev_write ||
        avm_read != prev_read || (avm_write && avm_writedata != prev_data)))
      stall_violations++;
    if (avm_chipselect && avm_waitrequest) stall_cycles++;
    if (avm_chipselect && !avm_waitrequest) begin
      if (avm_write) begin
        wr_addr_log.push_back(avm_address);
        wr_data_log.push_back(avm_writedata);
      end
      if (avm_read) rd_addr_log.push_back(avm_address);
    end
    prev_wait  = avm_chipselect && avm_waitrequest;
    prev_write = avm_write;
    prev_read  = avm_read;
    prev_addr  = avm_address;
    prev_data  = avm_writedata;
  end

  function automatic logic [31:0] wrAddrAt(input int i);
    return (i < wr_addr_log.size()) ? 32'(wr_addr_log[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wrDataAt(input int i);
    return (i < wr_data_log.size()) ? wr_data_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rdAddrAt(input int i);
    return (i < rd_addr_log.size()) ? 32'(rd_addr_log[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string ctx);
    checkOutput({ctx, "_busy"}, 32'(busy), 32'h0);
    checkOutput({ctx, "_done"}, 32'(done), 32'h0);
    checkOutput({ctx, "_pass"}, 32'(pass), 32'h0);
    checkOutput({ctx, "_cfg_err"}, 32'(cfg_err), 32'h0);
    checkOutput({ctx, "_err_count"}, 32'(err_count), 32'h0);
    checkOutput({ctx, "_first_err_addr"}, 32'(first_err_addr), 32'h0);
    checkOutput({ctx, "_avm_address"}, 32'(avm_address), 32'h0);
    checkOutput({ctx, "_avm_chipselect"}, 32'(avm_chipselect), 32'h0);
    checkOutput({ctx, "_avm_write"}, 32'(avm_write), 32'h0);
    checkOutput({ctx, "_avm_read"}, 32'(avm_read), 32'h0);
    checkOutput({ctx, "_avm_byteenable"}, 32'(avm_byteenable), 32'h0);
    checkOutput({ctx, "_avm_writedata"}, avm_writedata, 32'h0);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [13:0] l, input logic [31:0] s);
    @(negedge clk); #1;
    base_addr = b; length = l; seed = s; start = 1'b1; new_run = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; new_run = 1'b0;
  endtask

  // Counts clock edges from the start-sampling edge until done is visible.
  task automatic waitDone(input int max_cycles, output int cycles);
    cycles = 1;
    while (!done && cycles < max_cycles) begin
      @(negedge clk); #1;
      cycles++;
    end
    checkOutput("done_reached", 32'(done), 32'h1);
  endtask

  int cyc;
  int n;
  int snap;

  initial begin
    reset = 1'b1; start = 1'b1; base_addr = '0; length = '0; seed = '0;
    repeat (3) @(negedge clk);
    #1 checkAllZero("reset");
    start = 1'b0;
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkOutput("post_reset_busy", 32'(busy), 32'h0);
    checkOutput("post_reset_bus", 32'(cs_cycles), 32'h0);

    // Clean run
    applyStimulus(13'd0, 14'd4, 32'h1000_0000);
    waitDone(1000, cyc);
    checkOutput("clean_cycles", 32'(cyc), 32'd10);
    checkOutput("clean_pass", 32'(pass), 32'h1);
    checkOutput("clean_err_count", 32'(err_count), 32'h0);
    checkOutput("clean_cfg_err", 32'(cfg_err), 32'h0);
    checkOutput("clean_busy", 32'(busy), 32'h0);
    checkOutput("clean_cs_cycles", 32'(cs_cycles), 32'd8);
    checkOutput("clean_overlap", 32'(overlap_cycles), 32'h0);
    checkOutput("clean_wr_count", 32'(wr_addr_log.size()), 32'd4);
    checkOutput("clean_rd_count", 32'(rd_addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("clean_wr_addr", wrAddrAt(i), 32'(i));
      checkOutput("clean_wr_data", wrDataAt(i), 32'h1000_0000 + 32'(i));
      checkOutput("clean_rd_addr", rdAddrAt(i), 32'(i));
    end

    // Injected fault on addresses 2 and 3
    corrupt_a = 2; corrupt_b = 3;
    applyStimulus(13'd0, 14'd4, 32'h0BAD_0000);
    waitDone(1000, cyc);
    corrupt_a = -1; corrupt_b = -1;
    checkOutput("fault_err_count", 32'(err_count), 32'd2);
    checkOutput("fault_first_err_addr", 32'(first_err_addr), 32'd2);
    checkOutput("fault_pass", 32'(pass), 32'h0);
    checkOutput("fault_cfg_err", 32'(cfg_err), 32'h0);

    // Configuration errors: window past DEPTH, then zero length
    applyStimulus(13'd5000, 14'd121, 32'h0);
    waitDone(1000, cyc);
    checkOutput("cfg_cycles", 32'(cyc), 32'd1);
    checkOutput("cfg_cfg_err", 32'(cfg_err), 32'h1);
    checkOutput("cfg_pass", 32'(pass), 32'h0);
    checkOutput("cfg_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #1 checkOutput("cfg_cs_cycles", 32'(cs_cycles), 32'h0);
    applyStimulus(13'd0, 14'd0, 32'h0);
    waitDone(1000, cyc);
    checkOutput("len0_cfg_err", 32'(cfg_err), 32'h1);
    checkOutput("len0_cs_cycles", 32'(cs_cycles), 32'h0);

    // Window ending exactly at DEPTH
    applyStimulus(13'd5000, 14'd120, 32'h5555_0000);
    waitDone(2000, cyc);
    checkOutput("edge_cycles", 32'(cyc), 32'd242);
    checkOutput("edge_pass", 32'(pass), 32'h1);
    checkOutput("edge_cfg_err", 32'(cfg_err), 32'h0);
    checkOutput("edge_wr_count", 32'(wr_addr_log.size()), 32'd120);
    checkOutput("edge_last_wr_addr", wrAddrAt(119), 32'd5119);
    checkOutput("edge_last_wr_data", wrDataAt(119), 32'h5555_0077);
    checkOutput("edge_last_rd_addr", rdAddrAt(119), 32'd5119);

    // Stalls on the second write and the third read
    stall_en = 1'b1;
    applyStimulus(13'd100, 14'd5, 32'hA5A5_0000);
    waitDone(1000, cyc);
    stall_en = 1'b0;
    checkOutput("stall_cycles_total", 32'(cyc), 32'd18);
    checkOutput("stall_cycle_count", 32'(stall_cycles), 32'd6);
    checkOutput("stall_violations", 32'(stall_violations), 32'h0);
    checkOutput("stall_pass", 32'(pass), 32'h1);
    checkOutput("stall_wr_count", 32'(wr_addr_log.size()), 32'd5);
    checkOutput("stall_rd_count", 32'(rd_addr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_wr_addr", wrAddrAt(i), 32'd100 + 32'(i));
      checkOutput("stall_wr_data", wrDataAt(i), 32'hA5A5_0000 + 32'(i));
      checkOutput("stall_rd_addr", rdAddrAt(i), 32'd100 + 32'(i));
    end

    // Write data wraps modulo 2^32
    applyStimulus(13'd10, 14'd3, 32'hFFFF_FFFE);
    waitDone(1000, cyc);
    checkOutput("wrap_pass", 32'(pass), 32'h1);
    checkOutput("wrap_data0", wrDataAt(0), 32'hFFFF_FFFE);
    checkOutput("wrap_data1", wrDataAt(1), 32'hFFFF_FFFF);
    checkOutput("wrap_data2", wrDataAt(2), 32'h0000_0000);

    // Reset in the middle of the read phase
    applyStimulus(13'd10, 14'd3, 32'hFFFF_FFFE);
    n = 0;
    while (!avm_read && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("midrun_reached_read", 32'(avm_read), 32'h1);
    reset = 1'b1;
    #1 checkAllZero("midrun");
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    snap = cs_cycles;
    repeat (6) @(negedge clk);
    #1 checkOutput("midrun_no_bus", 32'(cs_cycles), 32'(snap));
    checkOutput("midrun_done", 32'(done), 32'h0);
    checkOutput("midrun_busy", 32'(busy), 32'h0);

    // Start pulsed while busy must be ignored
    applyStimulus(13'd0, 14'd6, 32'h2222_0000);
    @(negedge clk); #1;
    base_addr = 13'd300; length = 14'd2; seed = 32'h0; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    waitDone(1000, cyc);
    checkOutput("busy_start_pass", 32'(pass), 32'h1);
    checkOutput("busy_start_wr_count", 32'(wr_addr_log.size()), 32'd6);
    checkOutput("busy_start_rd_count", 32'(rd_addr_log.size()), 32'd6);
    checkOutput("busy_start_first_addr", wrAddrAt(0), 32'd0);
    checkOutput("busy_start_last_addr", wrAddrAt(5), 32'd5);
    checkOutput("busy_start_last_data", wrDataAt(5), 32'h2222_0005);
    checkOutput("busy_start_cs_cycles", 32'(cs_cycles), 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
